switch_load_capture: RTL and testbench

- Consumes the 1-bit software "load" level from the switches load PIO and the raw board slide switches.
- Synchronises and debounces the switches. On each rising edge of load, snapshots the debounced value into a holding register.
- Exposes the snapshot, status flags, an interrupt enable and a capture counter through a 4-word Avalon-MM slave with the same timing as the PIO slaves: combinational readdata, write on chipselect && ~write_n.

---
 rtl/switch_load_capture.sv | 126 ++++++++++++
 tb/tb_switch_load_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_load_capture.sv
// Switch snapshot peripheral: synchronises and debounces slide switches, captures the
// debounced value on each rising edge of the load level, exposes it via a 4-word Avalon-MM slave.
module switch_load_capture #(
    parameter int unsigned SW_WIDTH        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic                load,
    input  logic [SW_WIDTH-1:0] switches,
    output logic                irq
);

    localparam logic [19:0] LP_CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    logic                r_load_s1;
    logic                r_load_s2;
    logic                r_load_prev;
    logic [SW_WIDTH-1:0] r_sw_s1;
    logic [SW_WIDTH-1:0] r_sw_s2;
    logic [SW_WIDTH-1:0] r_candidate;
    logic [19:0]         r_counter;
    logic [SW_WIDTH-1:0] r_debounced;
    logic [SW_WIDTH-1:0] r_captured;
    logic                r_valid;
    logic                r_overflow;
    logic                r_irq_en;
    logic [7:0]          r_cap_count;

    logic w_cap_req;
    logic w_stable;
    logic w_wr;
    logic w_wr_status;
    logic w_wr_ctrl;
    logic w_unused;

    assign w_cap_req   = r_load_s2 & ~r_load_prev;
    assign w_stable    = (r_counter == LP_CNT_MAX);
    assign w_wr        = chipselect & ~write_n;
    assign w_wr_status = w_wr && (address == 2'd1);
    assign w_wr_ctrl   = w_wr && (address == 2'd2);
    assign w_unused    = ^writedata[31:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_s1   <= 1'b0;
            r_load_s2   <= 1'b0;
            r_load_prev <= 1'b0;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
        end else begin
            r_load_s1   <= load;
            r_load_s2   <= r_load_s1;
            r_load_prev <= r_load_s2;
            r_sw_s1     <= switches;
            r_sw_s2     <= r_sw_s1;
        end
    end

    // Counter saturates at the threshold so "stable" stays readable while inputs are quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_candidate <= '0;
            r_counter   <= '0;
            r_debounced <= '0;
        end else if (r_sw_s2 != r_candidate) begin
            r_candidate <= r_sw_s2;
            r_counter   <= '0;
        end else if (r_counter < LP_CNT_MAX) begin
            r_counter   <= r_counter + 20'd1;
        end else begin
            r_debounced <= r_candidate;
        end
    end

    // A capture outranks a same-cycle W1C; overflow is decided from valid before that write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_captured  <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_cap_count <= '0;
            r_irq_en    <= 1'b0;
        end else begin
            if (w_cap_req) begin
                r_captured  <= r_debounced;
                r_cap_count <= r_cap_count + 8'd1;
            end

            if (w_cap_req)
                r_valid <= 1'b1;
            else if (w_wr_status && writedata[0])
                r_valid <= 1'b0;

            if (w_cap_req && r_valid)
                r_overflow <= 1'b1;
            else if (w_wr_status && writedata[1])
                r_overflow <= 1'b0;

            if (w_wr_ctrl)
                r_irq_en <= writedata[0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[SW_WIDTH-1:0] = r_captured;
            2'd1: readdata[2:0]          = {w_stable, r_overflow, r_valid};
            2'd2: readdata[0]            = r_irq_en;
            2'd3: begin
                readdata[7:0]            = r_cap_count;
                readdata[SW_WIDTH+15:16] = r_debounced;
            end
            default: readdata = '0;
        endcase
    end

    assign irq = r_irq_en & r_valid;

endmodule

// File: tb/tb_switch_load_capture.sv
// Directed self-checking bench for switch_load_capture with a short debounce window.
module tb_switch_load_capture;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        load;
    logic [7:0]  switches;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    switch_load_capture #(
        .SW_WIDTH       (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .load      (load),
        .switches  (switches),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic pulse();
        load = 1'b1;
        tick(3);
        load = 1'b0;
        tick(3);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        load       = 1'b0;
        switches   = 8'hA5;

        // Reset state
        tick(3);
        rd_chk("rst_addr0", 2'd0, 32'h0);
        rd_chk("rst_addr1", 2'd1, 32'h0);
        rd_chk("rst_addr2", 2'd2, 32'h0);
        rd_chk("rst_addr3", 2'd3, 32'h0);
        irq_chk("rst_irq", 1'b0);

        // Release: 2 sync edges, candidate change on 3rd, stable after 6th, debounced on 7th
        reset_n = 1'b1;
        tick(5);
        rd_chk("deb_e5_status", 2'd1, 32'h0);
        tick(1);
        rd_chk("deb_e6_status", 2'd1, 32'h4);
        rd_chk("deb_e6_live", 2'd3, 32'h0);
        tick(1);
        rd_chk("deb_e7_live", 2'd3, 32'h00A5_0000);
        rd_chk("deb_e7_status", 2'd1, 32'h4);

        // Bounce rejection
        reset_n  = 1'b0;
        switches = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        rd_chk("bounce_pre", 2'd3, 32'h0);
        for (int i = 0; i < 10; i++) begin
            switches[0] = ~switches[0];
            tick(3);
            rd_chk("bounce_toggle", 2'd3, 32'h0);
        end
        switches = 8'h01;
        tick(6);
        rd_chk("bounce_hold6", 2'd3, 32'h0);
        tick(1);
        rd_chk("bounce_hold7", 2'd3, 32'h0001_0000);

        // Capture latency
        switches = 8'h3C;
        tick(10);
        rd_chk("cap_live", 2'd3, 32'h003C_0000);
        load = 1'b1;
        tick(1);
        rd_chk("cap_n_status", 2'd1, 32'h4);
        tick(1);
        rd_chk("cap_n1_status", 2'd1, 32'h4);
        rd_chk("cap_n1_data", 2'd0, 32'h0);
        tick(1);
        rd_chk("cap_n2_data", 2'd0, 32'h3C);
        rd_chk("cap_n2_status", 2'd1, 32'h5);
        tick(17);
        rd_chk("cap_hold_status", 2'd1, 32'h5);
        rd_chk("cap_hold_count", 2'd3, 32'h003C_0001);
        load = 1'b0;
        tick(3);

        // Ignored writes
        wr(2'd2, 32'h1, 1'b0);
        rd_chk("nocs_ctrl", 2'd2, 32'h0);
        wr(2'd0, 32'hFF, 1'b1);
        rd_chk("ro_addr0", 2'd0, 32'h3C);
        wr(2'd3, 32'hFFFF_FFFF, 1'b1);
        rd_chk("ro_addr3", 2'd3, 32'h003C_0001);

        // Overflow and W1C
        wr(2'd1, 32'h3, 1'b1);
        rd_chk("ovf_clear", 2'd1, 32'h4);
        pulse();
        pulse();
        rd_chk("ovf_status", 2'd1, 32'h7);
        rd_chk("ovf_count", 2'd3, 32'h003C_0003);
        wr(2'd1, 32'h2, 1'b1);
        rd_chk("w1c_ovf", 2'd1, 32'h5);
        wr(2'd1, 32'h1, 1'b1);
        rd_chk("w1c_valid", 2'd1, 32'h4);
        irq_chk("irq_disabled", 1'b0);

        // Interrupt and collision
        wr(2'd2, 32'h1, 1'b1);
        rd_chk("irq_en", 2'd2, 32'h1);
        irq_chk("irq_novalid", 1'b0);
        pulse();
        irq_chk("irq_set", 1'b1);
        rd_chk("irq_status", 2'd1, 32'h5);
        load = 1'b1;
        tick(2);
        wr(2'd1, 32'h1, 1'b1);
        rd_chk("coll_status", 2'd1, 32'h7);
        irq_chk("coll_irq", 1'b1);
        load = 1'b0;
        tick(3);
        wr(2'd1, 32'h1, 1'b1);
        irq_chk("irq_cleared", 1'b0);
        rd_chk("irq_clr_status", 2'd1, 32'h6);
        rd_chk("irq_count", 2'd3, 32'h003C_0005);

        // Counter wrap: 5 + 251 = 256 -> 0
        for (int i = 0; i < 251; i++) pulse();
        rd_chk("wrap_count", 2'd3, 32'h003C_0000);

        // Mid-debounce reset
        switches = 8'h5A;
        tick(5);
        reset_n = 1'b0;
        #1;
        rd_chk("mid_rst_addr0", 2'd0, 32'h0);
        rd_chk("mid_rst_addr1", 2'd1, 32'h0);
        rd_chk("mid_rst_addr2", 2'd2, 32'h0);
        rd_chk("mid_rst_addr3", 2'd3, 32'h0);
        irq_chk("mid_rst_irq", 1'b0);
        tick(3);
        reset_n = 1'b1;
        tick(3);
        rd_chk("post_rst_addr0", 2'd0, 32'h0);
        rd_chk("post_rst_addr1", 2'd1, 32'h0);
        rd_chk("post_rst_addr3", 2'd3, 32'h0);
        irq_chk("post_rst_irq", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
